// File: rtl/frame_pixel_source.sv
// Pixel responder for the VGA read port: renders sky, scrolling dashed ground,
// an animated dino box and an obstacle box from shadow state that only moves at end of frame.

module frame_pixel_source_chk #(
    parameter int ANIM_DIV = 8
) (
    input logic       vga_clk,
    input logic       clrn,
    input logic [9:0] scroll_x,
    input logic [7:0] anim_cnt,
    input logic       frame_tick
);
    localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

    // scroll offset must stay inside one screen width
    a_scroll_range: assert property (@(posedge vga_clk) disable iff (!clrn)
        scroll_x < 10'd640);

    // animation divider never runs past its terminal count
    a_anim_range: assert property (@(posedge vga_clk) disable iff (!clrn)
        anim_cnt <= ANIM_LAST);

    // the frame pulse is a single cycle wide
    a_tick_single: assert property (@(posedge vga_clk) disable iff (!clrn)
        frame_tick |=> !frame_tick);
endmodule

module frame_pixel_source #(
    parameter int          GROUND_Y = 400,
    parameter int          DINO_X   = 64,
    parameter int          SPEED    = 4,
    parameter int          ANIM_DIV = 8,
    parameter logic [11:0] SKY      = 12'hFDB,
    parameter logic [11:0] FG       = 12'h555,
    parameter logic [11:0] CRASH    = 12'h00F
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic [8:0]  dino_y,
    input  logic [9:0]  obst_x,
    input  logic        run,
    input  logic        crash,
    output logic [11:0] pixel,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);
    localparam logic [9:0]  DX_LO      = 10'(DINO_X);
    localparam logic [9:0]  DX_HI      = 10'(DINO_X + 31);
    localparam logic [8:0]  OB_TOP     = 9'(GROUND_Y - 32);
    localparam logic [8:0]  OB_BOT     = 9'(GROUND_Y - 1);
    localparam logic [8:0]  GND_ROW0   = 9'(GROUND_Y);
    localparam logic [8:0]  GND_ROW1   = 9'(GROUND_Y + 1);
    localparam logic [8:0]  DINO_Y_RST = 9'(GROUND_Y - 32);
    localparam logic [10:0] SPEED_W    = 11'(SPEED);
    localparam logic [7:0]  ANIM_LAST  = 8'(ANIM_DIV - 1);

    logic        rdn_q_r;
    logic        eof_s;
    logic [8:0]  dino_y_sh_r;
    logic [9:0]  obst_x_sh_r;
    logic        crash_sh_r;
    logic [9:0]  scroll_x_r;
    logic [7:0]  anim_cnt_r;
    logic        anim_ph_r;

    logic [10:0] scroll_sum_s;
    logic [9:0]  scroll_nxt_s;
    logic        dino_hit_s;
    logic        obst_hit_s;
    logic        ground_row_s;
    logic        ground_dark_s;
    logic [9:0]  row_rel_s;
    logic [10:0] gx_sum_s;
    logic [9:0]  gx_s;

    assign eof_s = rdn & ~rdn_q_r & (row_addr == 9'd479);

    // rdn edge history and the registered end-of-frame pulse / frame counter
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            rdn_q_r    <= 1'b1;
            frame_tick <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            rdn_q_r    <= rdn;
            frame_tick <= eof_s;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

    // next scroll offset, wrapped back into 0..639
    always_comb begin
        scroll_sum_s = {1'b0, scroll_x_r} + SPEED_W;
        if (scroll_sum_s >= 11'd640) begin
            scroll_nxt_s = 10'(scroll_sum_s - 11'd640);
        end else begin
            scroll_nxt_s = scroll_sum_s[9:0];
        end
    end

    // per-frame shadow state, updated only on the frame pulse so frames never tear
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            dino_y_sh_r <= DINO_Y_RST;
            obst_x_sh_r <= 10'd640;
            crash_sh_r  <= 1'b0;
            scroll_x_r  <= 10'd0;
            anim_cnt_r  <= 8'd0;
            anim_ph_r   <= 1'b0;
        end else if (frame_tick) begin
            dino_y_sh_r <= dino_y;
            obst_x_sh_r <= obst_x;
            crash_sh_r  <= crash;
            if (run) begin
                scroll_x_r <= scroll_nxt_s;
                if (anim_cnt_r == ANIM_LAST) begin
                    anim_cnt_r <= 8'd0;
                    anim_ph_r  <= ~anim_ph_r;
                end else begin
                    anim_cnt_r <= anim_cnt_r + 8'd1;
                    anim_ph_r  <= anim_ph_r;
                end
            end else begin
                scroll_x_r <= scroll_x_r;
                anim_cnt_r <= anim_cnt_r;
                anim_ph_r  <= anim_ph_r;
            end
        end else begin
            dino_y_sh_r <= dino_y_sh_r;
            obst_x_sh_r <= obst_x_sh_r;
            crash_sh_r  <= crash_sh_r;
            scroll_x_r  <= scroll_x_r;
            anim_cnt_r  <= anim_cnt_r;
            anim_ph_r   <= anim_ph_r;
        end
    end

    // sprite hit tests; dino rows compared in 10 bits so dino_y near 511 cannot wrap
    always_comb begin
        row_rel_s  = {1'b0, row_addr} - {1'b0, dino_y_sh_r};
        dino_hit_s = 1'b0;
        if ((col_addr >= DX_LO) && (col_addr <= DX_HI) &&
            ({1'b0, row_addr} >= {1'b0, dino_y_sh_r}) &&
            ({1'b0, row_addr} <= ({1'b0, dino_y_sh_r} + 10'd31))) begin
            // the bottom 8 rows are legs, striped by column bit 2 against the phase
            if (row_rel_s >= 10'd24) begin
                dino_hit_s = (col_addr[2] == anim_ph_r);
            end else begin
                dino_hit_s = 1'b1;
            end
        end else begin
            dino_hit_s = 1'b0;
        end

        obst_hit_s = (obst_x_sh_r < 10'd640) &&
                     ({1'b0, col_addr} >= {1'b0, obst_x_sh_r}) &&
                     ({1'b0, col_addr} <= ({1'b0, obst_x_sh_r} + 11'd15)) &&
                     (row_addr >= OB_TOP) && (row_addr <= OB_BOT);
    end

    // ground dash pattern: column shifted by scroll, wrapped at the screen width
    always_comb begin
        gx_sum_s = {1'b0, col_addr} + {1'b0, scroll_x_r};
        if (gx_sum_s >= 11'd640) begin
            gx_s = 10'(gx_sum_s - 11'd640);
        end else begin
            gx_s = gx_sum_s[9:0];
        end
        ground_row_s  = (row_addr == GND_ROW0) || (row_addr == GND_ROW1);
        ground_dark_s = ((gx_s & 10'd8) == 10'd0);
    end

    // zero-latency pixel mux in priority order
    always_comb begin
        pixel = 12'h000;
        if (rdn) begin
            pixel = 12'h000;
        end else if (dino_hit_s) begin
            pixel = crash_sh_r ? CRASH : FG;
        end else if (obst_hit_s) begin
            pixel = FG;
        end else if (ground_row_s) begin
            pixel = ground_dark_s ? FG : SKY;
        end else begin
            pixel = SKY;
        end
    end

    frame_pixel_source_chk #(
        .ANIM_DIV (ANIM_DIV)
    ) u_chk (
        .vga_clk    (vga_clk),
        .clrn       (clrn),
        .scroll_x   (scroll_x_r),
        .anim_cnt   (anim_cnt_r),
        .frame_tick (frame_tick)
    );
endmodule

// File: tb/tb_frame_pixel_source.sv
// Scoreboard bench for frame_pixel_source: directed frames and pixel probes,
// expected values queued by the stimulus and compared by a negedge monitor.

module tb_frame_pixel_source;
    localparam logic [11:0] SKY   = 12'hFDB;
    localparam logic [11:0] FG    = 12'h555;
    localparam logic [11:0] CRASH = 12'h00F;

    logic        vga_clk = 1'b0;
    logic        clrn    = 1'b0;
    logic [8:0]  row_addr = 9'd0;
    logic [9:0]  col_addr = 10'd0;
    logic        rdn      = 1'b1;
    logic [8:0]  dino_y   = 9'd368;
    logic [9:0]  obst_x   = 10'd640;
    logic        run      = 1'b0;
    logic        crash    = 1'b0;
    logic [11:0] pixel;
    logic        frame_tick;
    logic [15:0] frame_cnt;

    frame_pixel_source dut (
        .vga_clk    (vga_clk),
        .clrn       (clrn),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .rdn        (rdn),
        .dino_y     (dino_y),
        .obst_x     (obst_x),
        .run        (run),
        .crash      (crash),
        .pixel      (pixel),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct {
        int          kind;   // 0 pixel, 1 frame_cnt, 2 tick count, 3 frame_tick
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          tick_cnt = 0;
    logic        chk_v    = 1'b0;
    exp_t        mon_e;
    logic [15:0] mon_act;

    // monitor: pop one expectation per strobed cycle, also count frame pulses
    always @(negedge vga_clk) begin
        if (chk_v) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: got a check strobe with no expected value");
            end else begin
                mon_e = exp_q.pop_front();
                case (mon_e.kind)
                    0:       mon_act = {4'h0, pixel};
                    1:       mon_act = frame_cnt;
                    2:       mon_act = 16'(tick_cnt);
                    default: mon_act = {15'd0, frame_tick};
                endcase
                if (mon_act !== mon_e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.val);
                end
            end
        end
        if (frame_tick === 1'b1) tick_cnt++;
    end

    task automatic chk(input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
        chk_v = 1'b1;
        @(posedge vga_clk);
        #1;
        chk_v = 1'b0;
    endtask

    task automatic drive(input logic [8:0] r, input logic [9:0] c, input logic rd);
        row_addr = r;
        col_addr = c;
        rdn      = rd;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic px(input logic [8:0] r, input logic [9:0] c, input logic [11:0] e,
                      input string name);
        row_addr = r;
        col_addr = c;
        rdn      = 1'b0;
        chk(0, {4'h0, e}, name);
    endtask

    // minimal frame: just rows 478 and 479 with a rising rdn, then blanking
    task automatic short_frame();
        drive(9'd478, 10'd0, 1'b0);
        drive(9'd478, 10'd640, 1'b1);
        drive(9'd479, 10'd0, 1'b0);
        drive(9'd479, 10'd640, 1'b1);
        drive(9'd480, 10'd0, 1'b1);
        drive(9'd480, 10'd0, 1'b1);
        drive(9'd0, 10'd0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int ticks0;
        repeat (3) @(posedge vga_clk);
        #1;
        clrn = 1'b1;
        @(posedge vga_clk);
        #1;

        // reset state and plain sky
        px(9'd10, 10'd10, SKY, "reset_sky");
        chk(1, 16'd0, "reset_frame_cnt");
        chk(3, 16'd0, "reset_frame_tick");
        rdn = 1'b1;
        chk(0, 16'd0, "blank_pixel_zero");

        // one compressed full frame: rows 0-479 visible, 480-524 blank
        ticks0 = tick_cnt;
        for (int r = 0; r < 479; r++) begin
            drive(9'(r), 10'd0, 1'b0);
            drive(9'(r), 10'd640, 1'b1);
        end
        chk(2, 16'(ticks0), "no_tick_rows_0_478");
        drive(9'd479, 10'd0, 1'b0);
        row_addr = 9'd479;
        col_addr = 10'd640;
        rdn      = 1'b1;
        chk(3, 16'd0, "tick_low_on_rise");
        chk(3, 16'd1, "tick_high_next");
        chk(3, 16'd0, "tick_one_cycle");
        for (int r = 480; r < 525; r++) begin
            drive(9'd480, 10'd0, 1'b1);
        end
        chk(2, 16'(ticks0 + 1), "one_tick_per_frame");
        chk(1, 16'd1, "frame_cnt_1");

        // shadowed dino position ignores mid-frame changes
        dino_y = 9'd300;
        short_frame();
        px(9'd310, 10'd70, FG, "dino_at_300");
        dino_y = 9'd200;
        px(9'd310, 10'd70, FG, "dino_still_300");
        px(9'd210, 10'd70, SKY, "dino_not_yet_200");
        short_frame();
        px(9'd210, 10'd70, FG, "dino_at_200");
        px(9'd310, 10'd70, SKY, "old_dino_gone");
        px(9'd231, 10'd64, FG, "leg_col_bit2_0");
        px(9'd231, 10'd95, SKY, "leg_col_bit2_1");
        px(9'd232, 10'd64, SKY, "below_dino");
        px(9'd210, 10'd96, SKY, "right_of_dino");
        chk(1, 16'd3, "frame_cnt_3");

        // scroll 160 frames of 4 px wraps to 0
        dino_y = 9'd368;
        run    = 1'b1;
        repeat (160) short_frame();
        px(9'd400, 10'd0, FG, "ground_wrap_col0");
        px(9'd400, 10'd8, SKY, "ground_wrap_col8");
        short_frame();
        px(9'd401, 10'd4, SKY, "ground_s4_col4");
        px(9'd401, 10'd0, FG, "ground_s4_col0");
        px(9'd401, 10'd636, FG, "gx_wrap_636");
        px(9'd401, 10'd635, SKY, "gx_639");
        chk(1, 16'd164, "frame_cnt_164");

        // reset in the middle of a frame
        run = 1'b0;
        drive(9'd100, 10'd5, 1'b0);
        drive(9'd100, 10'd6, 1'b0);
        #5;
        clrn = 1'b0;
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        clrn = 1'b1;
        chk(1, 16'd0, "midreset_frame_cnt");
        px(9'd401, 10'd4, FG, "midreset_scroll0");

        // leg animation toggles after ANIM_DIV running frames
        dino_y = 9'd300;
        short_frame();
        chk(1, 16'd1, "post_reset_tick");
        px(9'd328, 10'd68, SKY, "leg_ph0_col68");
        px(9'd328, 10'd64, FG, "leg_ph0_col64");
        run = 1'b1;
        repeat (7) short_frame();
        px(9'd328, 10'd68, SKY, "leg_7frames");
        short_frame();
        run = 1'b0;
        px(9'd328, 10'd68, FG, "leg_ph1_col68");
        px(9'd328, 10'd64, SKY, "leg_ph1_col64");
        chk(1, 16'd9, "frame_cnt_9");

        // crash colour, obstacle overlap and priority
        crash  = 1'b1;
        obst_x = 10'd70;
        dino_y = 9'd368;
        px(9'd310, 10'd70, FG, "crash_not_sampled");
        short_frame();
        px(9'd380, 10'd70, CRASH, "overlap_crash");
        px(9'd396, 10'd70, CRASH, "leg_crash");
        px(9'd396, 10'd72, FG, "leg_gap_obst");
        px(9'd396, 10'd88, SKY, "leg_gap_sky");
        px(9'd367, 10'd70, SKY, "above_obst");
        obst_x = 10'd700;
        crash  = 1'b0;
        short_frame();
        px(9'd396, 10'd72, SKY, "obst_offscreen");
        px(9'd380, 10'd70, FG, "dino_normal");
        obst_x = 10'd600;
        short_frame();
        px(9'd390, 10'd615, FG, "obst_right_edge");
        px(9'd390, 10'd616, SKY, "obst_past_right");
        px(9'd390, 10'd599, SKY, "obst_before_left");
        chk(1, 16'd12, "frame_cnt_12");

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
